uw_frame_insert: RTL and testbench

Transmit-side framer for the LRPT path: takes a serial hard-bit payload stream and emits a burst of NUM_FRAMES frames, each an 8-bit unique word (UW) followed by BITS_PER_FRAME-8 payload bits. Its output matches the frame format the UW correlator/deinterleave stage locks onto. The UW is selected per burst from the four rotation variants, so receiver rotation and offset search can be exercised in loopback and on the bench. Valid/ready handshakes are used on both sides, with a single registered output stage.

---
 rtl/uw_frame_insert.sv | 194 +++++++++++++++++++
 tb/tb_uw_frame_insert.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uw_frame_insert.sv
`default_nettype none
// ============================================================================
// Module   : uw_frame_insert
// Purpose  : Transmit-side LRPT framer. Emits a burst of NUM_FRAMES frames,
//            each an 8-bit unique word (rotation-selected) followed by
//            BITS_PER_FRAME-UW_BITS payload bits taken from a serial stream.
//            Valid/ready on both sides, single registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module uw_frame_insert #(
    parameter int          BITS_PER_FRAME = 80,
    parameter int          UW_BITS        = 8,
    parameter int          NUM_FRAMES     = 32,
    parameter logic [31:0] SYNC_WORDS     = 32'h274ED8B1
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic [1:0] rotation_in,
    input  logic       hard_inp,
    input  logic       valid_in,
    output logic       ready_rx,
    output logic       hard_out,
    output logic       valid_out,
    input  logic       out_ready,
    output logic       frame_start,
    output logic       burst_done,
    output logic       busy
);

    localparam int BCW = $clog2(BITS_PER_FRAME);
    localparam int FCW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    localparam logic [BCW-1:0] c_LAST_BIT   = BCW'(BITS_PER_FRAME - 1);
    localparam logic [BCW-1:0] c_UW_LAST    = BCW'(UW_BITS - 1);
    localparam logic [BCW-1:0] c_DATA_FIRST = BCW'(UW_BITS);
    localparam logic [FCW-1:0] c_LAST_FRAME = FCW'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UW   = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BCW-1:0]   r_bit_ctr;
    logic [BCW-1:0]   w_bit_ctr_nxt;
    logic [FCW-1:0]   r_frame_ctr;
    logic [FCW-1:0]   w_frame_ctr_nxt;
    logic [1:0]       r_rot;
    logic [1:0]       w_rot_nxt;

    logic             r_hard_out;
    logic             r_valid_out;
    logic             r_frame_start;
    logic             r_burst_done;

    logic             w_free;
    logic             w_busy;
    logic             w_ready_rx;
    logic             w_load;
    logic             w_load_bit;
    logic             w_load_fs;
    logic             w_done;
    logic [7:0]       w_uw_byte;
    logic [7:0]       w_start_byte;
    logic [2:0]       w_uw_idx;

    // Byte r of the sync table (r=0 is the most significant byte)
    function automatic logic [7:0] f_uw_byte(input logic [1:0] rot);
        logic [7:0] b;
        case (rot)
            2'd0:    b = SYNC_WORDS[31:24];
            2'd1:    b = SYNC_WORDS[23:16];
            2'd2:    b = SYNC_WORDS[15:8];
            default: b = SYNC_WORDS[7:0];
        endcase
        return b;
    endfunction

    // The output register may take a new bit when empty or being drained
    assign w_free       = !r_valid_out || out_ready;
    assign w_busy       = (r_state != S_IDLE) || r_valid_out;
    assign w_uw_byte    = f_uw_byte(r_rot);
    assign w_start_byte = f_uw_byte(rotation_in);
    assign w_uw_idx     = 3'(3'd7 - r_bit_ctr[2:0]);

    assign ready_rx    = w_ready_rx;
    assign hard_out    = r_hard_out;
    assign valid_out   = r_valid_out;
    assign frame_start = r_frame_start;
    assign burst_done  = r_burst_done;
    assign busy        = w_busy;

    // Next-state, counter updates and the bit to load into the output stage
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_ctr_nxt   = r_bit_ctr;
        w_frame_ctr_nxt = r_frame_ctr;
        w_rot_nxt       = r_rot;
        w_load          = 1'b0;
        w_load_bit      = 1'b0;
        w_load_fs       = 1'b0;
        w_done          = 1'b0;
        w_ready_rx      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // busy=0 guarantees the output stage is empty here
                if (start_in && !w_busy) begin
                    w_rot_nxt       = rotation_in;
                    w_load          = 1'b1;
                    w_load_bit      = w_start_byte[7];
                    w_load_fs       = 1'b1;
                    w_bit_ctr_nxt   = BCW'(1);
                    w_frame_ctr_nxt = '0;
                    w_state_nxt     = S_UW;
                end
            end
            S_UW: begin
                if (w_free) begin
                    w_load     = 1'b1;
                    w_load_bit = w_uw_byte[w_uw_idx];
                    w_load_fs  = (r_bit_ctr == '0);
                    if (r_bit_ctr == c_UW_LAST) begin
                        w_bit_ctr_nxt = c_DATA_FIRST;
                        w_state_nxt   = S_DATA;
                    end else begin
                        w_bit_ctr_nxt = r_bit_ctr + BCW'(1);
                    end
                end
            end
            S_DATA: begin
                w_ready_rx = w_free;
                if (valid_in && w_free) begin
                    w_load     = 1'b1;
                    w_load_bit = hard_inp;
                    if (r_bit_ctr == c_LAST_BIT) begin
                        w_bit_ctr_nxt = '0;
                        if (r_frame_ctr == c_LAST_FRAME) begin
                            w_state_nxt = S_IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_frame_ctr_nxt = r_frame_ctr + FCW'(1);
                            w_state_nxt     = S_UW;
                        end
                    end else begin
                        w_bit_ctr_nxt = r_bit_ctr + BCW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_bit_ctr   <= '0;
            r_frame_ctr <= '0;
            r_rot       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_ctr   <= w_bit_ctr_nxt;
            r_frame_ctr <= w_frame_ctr_nxt;
            r_rot       <= w_rot_nxt;
        end
    end

    // Output stage: load on a new bit, drain when free and idle, else hold
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_hard_out    <= 1'b0;
            r_valid_out   <= 1'b0;
            r_frame_start <= 1'b0;
            r_burst_done  <= 1'b0;
        end else begin
            r_burst_done <= w_done;
            if (w_load) begin
                r_hard_out    <= w_load_bit;
                r_valid_out   <= 1'b1;
                r_frame_start <= w_load_fs;
            end else if (w_free) begin
                r_valid_out   <= 1'b0;
                r_frame_start <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uw_frame_insert.sv
`default_nettype none
// ============================================================================
// Module   : tb_uw_frame_insert
// Purpose  : Directed self-checking bench for uw_frame_insert (2-frame bursts)
// Revision : 1.0 - initial release
// ============================================================================
module tb_uw_frame_insert;

    localparam int BPF   = 80;
    localparam int NF    = 2;
    localparam int TOTAL = BPF * NF;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       start_in = 1'b0;
    logic [1:0] rotation_in = 2'd0;
    logic       hard_inp = 1'b0;
    logic       valid_in = 1'b0;
    logic       out_ready = 1'b1;
    logic       ready_rx, hard_out, valid_out, frame_start, burst_done, busy;

    always #5 clk = ~clk;

    uw_frame_insert #(
        .BITS_PER_FRAME(BPF),
        .UW_BITS       (8),
        .NUM_FRAMES    (NF),
        .SYNC_WORDS    (32'h274ED8B1)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .rotation_in(rotation_in),
        .hard_inp   (hard_inp),
        .valid_in   (valid_in),
        .ready_rx   (ready_rx),
        .hard_out   (hard_out),
        .valid_out  (valid_out),
        .out_ready  (out_ready),
        .frame_start(frame_start),
        .burst_done (burst_done),
        .busy       (busy)
    );

    int   checks = 0;
    int   errors = 0;

    // Results of the last burst run
    logic q_bits[$];
    logic q_fs[$];
    int   xfer, done_cnt, done_idx, stall_err, rx_err, gap, timeout;
    logic busy_end, abort_vo, abort_busy;

    // Payload pattern: 0 = all ones, 1 = alternating 1,0,...
    function automatic logic pat_bit(input int pat, input int n);
        return (pat == 0) ? 1'b1 : ((n % 2) == 0);
    endfunction

    // Expected i-th output bit of a burst
    function automatic logic exp_bit(input int rot, input int pat, input int i);
        logic [7:0] uw;
        int j, p;
        case (rot)
            0:       uw = 8'h27;
            1:       uw = 8'h4E;
            2:       uw = 8'hD8;
            default: uw = 8'hB1;
        endcase
        j = i % BPF;
        if (j < 8) return uw[7-j];
        p = (i / BPF) * (BPF - 8) + (j - 8);
        return pat_bit(pat, p);
    endfunction

    function automatic int count_bad(input int rot, input int pat);
        int n = 0;
        for (int i = 0; i < q_bits.size(); i++)
            if (q_bits[i] !== exp_bit(rot, pat, i)) n++;
        return n;
    endfunction

    function automatic int count_bad_fs();
        int n = 0;
        for (int i = 0; i < q_fs.size(); i++)
            if (q_fs[i] !== ((i % BPF) == 0)) n++;
        return n;
    endfunction

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b = 8'hxx;
        if (q_bits.size() >= base + 8)
            for (int k = 0; k < 8; k++) b[7-k] = q_bits[base+k];
        return b;
    endfunction

    // Drive one burst and record what came out
    task automatic run_burst(input logic [1:0] rot, input int pat, input int rdy_pct,
                             input int vld_pct, input int abort_at, input int poke_at);
        int   in_cnt, loaded, cyc;
        logic prev_stall, prev_h, prev_fs, acc, xf;
        q_bits.delete(); q_fs.delete();
        xfer = 0; done_cnt = 0; done_idx = -1; stall_err = 0; rx_err = 0; gap = 0;
        timeout = 0; busy_end = 1'b1; abort_vo = 1'b1; abort_busy = 1'b1;
        in_cnt = 0; prev_stall = 1'b0; prev_h = 1'b0; prev_fs = 1'b0;
        start_in = 1'b1; rotation_in = rot; out_ready = 1'b1; valid_in = 1'b0; hard_inp = 1'b0;
        @(posedge clk); #1;
        start_in = 1'b0; rotation_in = 2'd0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            loaded = xfer + (valid_out ? 1 : 0);
            if (burst_done) begin done_cnt++; done_idx = loaded - 1; end
            if (prev_stall && (valid_out !== 1'b1 || hard_out !== prev_h || frame_start !== prev_fs))
                stall_err++;
            if (xfer == TOTAL) begin busy_end = busy; break; end
            if (!valid_out) gap++;
            if (abort_at >= 0 && xfer == abort_at) begin
                rst_in = 1'b1;
                @(posedge clk); #1;
                rst_in = 1'b0;
                abort_vo = valid_out; abort_busy = busy;
                valid_in = 1'b0; out_ready = 1'b1;
                return;
            end
            start_in    = (poke_at >= 0 && xfer == poke_at);
            rotation_in = start_in ? 2'd3 : 2'd0;
            out_ready   = ($urandom_range(99) < rdy_pct);
            valid_in    = ($urandom_range(99) < vld_pct);
            hard_inp    = pat_bit(pat, in_cnt);
            #1;
            if (ready_rx && (((loaded % BPF) < 8) || loaded >= TOTAL)) rx_err++;
            acc = valid_in && ready_rx;
            xf  = valid_out && out_ready;
            prev_stall = valid_out && !out_ready;
            prev_h  = hard_out;
            prev_fs = frame_start;
            @(posedge clk); #1;
            if (acc) in_cnt++;
            if (xf) begin q_bits.push_back(prev_h); q_fs.push_back(prev_fs); xfer++; end
        end
        if (cyc >= 3000) timeout = 1;
        start_in = 1'b0; valid_in = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) begin
            start_in = 1'($urandom); rotation_in = 2'($urandom); hard_inp = 1'($urandom);
            valid_in = 1'($urandom); out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        checks++; if (hard_out !== 1'b0)    begin errors++; $display("FAIL reset_hard_out got %b exp 0", hard_out); end
        checks++; if (valid_out !== 1'b0)   begin errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
        checks++; if (burst_done !== 1'b0)  begin errors++; $display("FAIL reset_burst_done got %b exp 0", burst_done); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ready_rx !== 1'b0)    begin errors++; $display("FAIL reset_ready_rx got %b exp 0", ready_rx); end
        rst_in = 1'b0; start_in = 1'b0; valid_in = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready_rx !== 1'b0 || valid_out !== 1'b0)
            begin errors++; $display("FAIL idle_no_start ready_rx=%b valid_out=%b exp 0 0", ready_rx, valid_out); end
        valid_in = 1'b0;
    endtask

    task automatic test_nominal();
        int bad;
        run_burst(2'd0, 0, 100, 100, -1, -1);
        checks++; if (timeout != 0) begin errors++; $display("FAIL nom_timeout got %0d exp 0", timeout); end
        checks++; if (q_bits.size() != TOTAL) begin errors++; $display("FAIL nom_count got %0d exp %0d", q_bits.size(), TOTAL); end
        bad = count_bad(0, 0);
        checks++; if (bad != 0) begin errors++; $display("FAIL nom_sequence bad_bits got %0d exp 0", bad); end
        checks++; if (get_byte(0) !== 8'h27 || get_byte(80) !== 8'h27)
            begin errors++; $display("FAIL nom_uw got %h/%h exp 27/27", get_byte(0), get_byte(80)); end
        bad = count_bad_fs();
        checks++; if (bad != 0) begin errors++; $display("FAIL nom_frame_start bad got %0d exp 0", bad); end
        checks++; if (done_cnt != 1 || done_idx != TOTAL - 1)
            begin errors++; $display("FAIL nom_burst_done cnt/idx got %0d/%0d exp 1/%0d", done_cnt, done_idx, TOTAL - 1); end
        checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL nom_busy_end got %b exp 0", busy_end); end
        checks++; if (rx_err != 0) begin errors++; $display("FAIL nom_ready_rx_in_uw got %0d exp 0", rx_err); end
        checks++; if (gap != 0) begin errors++; $display("FAIL nom_bubbles got %0d exp 0", gap); end
    endtask

    task automatic test_rotations();
        logic [7:0] uw_exp [4];
        int bad;
        uw_exp = '{8'h27, 8'h4E, 8'hD8, 8'hB1};
        for (int r = 1; r < 4; r++) begin
            run_burst(2'(r), 1, 100, 100, -1, -1);
            bad = count_bad(r, 1);
            checks++; if (q_bits.size() != TOTAL || bad != 0)
                begin errors++; $display("FAIL rot%0d_sequence count %0d bad %0d exp %0d 0", r, q_bits.size(), bad, TOTAL); end
            checks++; if (get_byte(0) !== uw_exp[r] || get_byte(80) !== uw_exp[r])
                begin errors++; $display("FAIL rot%0d_uw got %h/%h exp %h", r, get_byte(0), get_byte(80), uw_exp[r]); end
        end
    endtask

    task automatic test_stall();
        int bad;
        run_burst(2'd0, 0, 50, 100, -1, -1);
        bad = count_bad(0, 0);
        checks++; if (q_bits.size() != TOTAL || bad != 0)
            begin errors++; $display("FAIL stall_sequence count %0d bad %0d exp %0d 0", q_bits.size(), bad, TOTAL); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_hold got %0d exp 0", stall_err); end
        bad = count_bad_fs();
        checks++; if (bad != 0 || done_cnt != 1)
            begin errors++; $display("FAIL stall_fs_done bad_fs %0d done %0d exp 0 1", bad, done_cnt); end
    endtask

    task automatic test_gaps();
        int bad;
        run_burst(2'd2, 1, 100, 60, -1, -1);
        bad = count_bad(2, 1);
        checks++; if (q_bits.size() != TOTAL || bad != 0)
            begin errors++; $display("FAIL gaps_sequence count %0d bad %0d exp %0d 0", q_bits.size(), bad, TOTAL); end
        checks++; if (rx_err != 0) begin errors++; $display("FAIL gaps_ready_rx_in_uw got %0d exp 0", rx_err); end
        bad = count_bad_fs();
        checks++; if (bad != 0 || done_cnt != 1 || done_idx != TOTAL - 1)
            begin errors++; $display("FAIL gaps_framing bad_fs %0d done %0d idx %0d exp 0 1 %0d", bad, done_cnt, done_idx, TOTAL - 1); end
    endtask

    task automatic test_abuse_start();
        int bad;
        run_burst(2'd1, 1, 100, 100, -1, 20);
        bad = count_bad(1, 1);
        checks++; if (q_bits.size() != TOTAL || bad != 0)
            begin errors++; $display("FAIL midstart_sequence count %0d bad %0d exp %0d 0", q_bits.size(), bad, TOTAL); end
        checks++; if (get_byte(80) !== 8'h4E)
            begin errors++; $display("FAIL midstart_uw got %h exp 4e", get_byte(80)); end
    endtask

    task automatic test_reset_mid();
        int bad;
        run_burst(2'd0, 0, 100, 100, 40, -1);
        checks++; if (abort_vo !== 1'b0 || abort_busy !== 1'b0)
            begin errors++; $display("FAIL midreset_outputs valid_out %b busy %b exp 0 0", abort_vo, abort_busy); end
        checks++; if (q_bits.size() != 40)
            begin errors++; $display("FAIL midreset_count got %0d exp 40", q_bits.size()); end
        run_burst(2'd0, 0, 100, 100, -1, -1);
        bad = count_bad(0, 0);
        checks++; if (q_bits.size() != TOTAL || bad != 0)
            begin errors++; $display("FAIL restart_sequence count %0d bad %0d exp %0d 0", q_bits.size(), bad, TOTAL); end
        checks++; if (q_fs.size() == 0 || q_fs[0] !== 1'b1 || get_byte(0) !== 8'h27)
            begin errors++; $display("FAIL restart_first_uw byte %h exp 27", get_byte(0)); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rotations();
        test_stall();
        test_gaps();
        test_abuse_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute run-time bound
    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
